pixel_frame_writer: RTL and testbench

Downstream sink for the blurring filter's pixel stream. Takes each valid 12-bit RGB444 pixel (`ready_out`/`data_out` of the filter), tracks its raster position against the runtime image dimensions, and issues one registered write per pixel into a frame-buffer RAM port. Raises a one-cycle `frame_done` when the last pixel of the frame is written, and flags any stray pixels that arrive outside an armed frame.

---
 rtl/vfx_pkg.sv | 15 +
 rtl/pixel_frame_writer_raster_counter.sv | 52 +++++
 rtl/pixel_frame_writer.sv | 143 ++++++++++++++
 tb/tb_pixel_frame_writer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vfx_pkg.sv
// Shared video-effects package: state encodings,
// pixel width and default frame dimensions.
package vfx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } fw_state_t;

  localparam int PIXEL_W    = 12;
  localparam int DEF_WIDTH  = 320;
  localparam int DEF_HEIGHT = 240;

endpackage

// File: rtl/pixel_frame_writer_raster_counter.sv
// Raster x/y position counter with line/frame wrap
// and a combinational last-pixel flag for the current advance.
module raster_counter #(
  parameter int DIM_W = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic             last_pixel
);

  logic [DIM_W-1:0] x_q, x_d;
  logic [DIM_W-1:0] y_q, y_d;
  logic [DIM_W-1:0] x_base;
  logic [DIM_W-1:0] y_base;
  logic             x_end;
  logic             y_end;

  // Next position: clear takes effect before the advance of the same cycle
  always_comb begin
    x_base     = clr ? '0 : x_q;
    y_base     = clr ? '0 : y_q;
    x_end      = (x_base == width - DIM_W'(1));
    y_end      = (y_base == height - DIM_W'(1));
    x_d        = x_base;
    y_d        = y_base;
    last_pixel = adv && x_end && y_end;
    if (adv) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_base + DIM_W'(1);
      end else begin
        x_d = x_base + DIM_W'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/pixel_frame_writer.sv
// Frame writer: turns a valid pixel stream into registered
// frame-buffer writes and reports frame completion and strays.
module pixel_frame_writer
  import vfx_pkg::*;
#(
  parameter int DATA_W    = PIXEL_W,
  parameter int DIM_W     = 10,
  parameter int ADDR_W    = 17,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  image_width,
  input  logic [DIM_W-1:0]  image_height,
  input  logic              ready_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  fw_state_t         state_q, state_d;
  logic [DIM_W-1:0]  w_q, w_d;
  logic [DIM_W-1:0]  h_q, h_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;

  logic              start_ok;
  logic              accept;
  logic              last;
  logic [DIM_W-1:0]  eff_w;
  logic [DIM_W-1:0]  eff_h;
  logic [ADDR_W-1:0] addr_base;

  // An honoured start rebases the frame in the same cycle,
  // so a coincident pixel lands at (0,0) of the new frame.
  always_comb begin
    start_ok  = start && (|image_width) && (|image_height);
    eff_w     = start_ok ? image_width : w_q;
    eff_h     = start_ok ? image_height : h_q;
    addr_base = start_ok ? '0 : addr_cnt_q;
    accept    = ready_in && (start_ok || (state_q == CAPTURE));
  end

  raster_counter #(
    .DIM_W (DIM_W)
  ) u_raster (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (start_ok),
    .adv        (accept),
    .width      (eff_w),
    .height     (eff_h),
    .last_pixel (last)
  );

  // Next state, counters and registered write port
  always_comb begin
    state_d      = state_q;
    w_d          = eff_w;
    h_d          = eff_h;
    addr_cnt_d   = accept ? addr_base + ADDR_W'(1) : addr_base;
    wr_en_d      = accept;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = accept && last;
    overflow_d   = overflow_q;

    if (accept) begin
      wr_addr_d = BASE + addr_base;
      wr_data_d = data_in;
    end

    if (start_ok) begin
      overflow_d = 1'b0;
    end else if (ready_in && !accept) begin
      overflow_d = 1'b1;
    end

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_ok) begin
          state_d = (accept && last) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (accept && last) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CAPTURE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      w_q          <= '0;
      h_q          <= '0;
      addr_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      h_q          <= h_d;
      addr_cnt_q   <= addr_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Bench for pixel_frame_writer: directed frames plus random
// traffic checked against a pixel-index frame model.
module tb_pixel_frame_writer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [9:0]  image_width;
  logic [9:0]  image_height;
  logic        ready_in;
  logic [11:0] data_in;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        busy;
  logic        frame_done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  // frame model: active frame, pixel index, dims, sticky flag
  bit m_active;
  int m_idx;
  int m_w;
  int m_h;
  bit m_ovf;
  bit e_en;
  int e_addr;
  int e_data;
  bit e_done;
  int n_done;

  pixel_frame_writer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .image_width  (image_width),
    .image_height (image_height),
    .ready_in     (ready_in),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .frame_done   (frame_done),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_idx    = 0;
    m_w      = 0;
    m_h      = 0;
    m_ovf    = 0;
  endtask

  task automatic step(input bit s, input int w, input int h,
                      input bit r, input int d);
    start        = s;
    image_width  = 10'(w);
    image_height = 10'(h);
    ready_in     = r;
    data_in      = 12'(d);
    e_en   = 0;
    e_done = 0;
    if (s && w != 0 && h != 0) begin
      m_active = 1;
      m_idx    = 0;
      m_w      = w;
      m_h      = h;
      m_ovf    = 0;
    end
    if (r && m_active) begin
      e_en   = 1;
      e_addr = m_idx;
      e_data = d & 12'hFFF;
      if (m_idx == m_w * m_h - 1) begin
        e_done   = 1;
        m_active = 0;
      end
      m_idx++;
    end else if (r) begin
      m_ovf = 1;
    end
    @(posedge clk);
    #1;
    start    = 0;
    ready_in = 0;
    chk("wr_en", int'(wr_en), int'(e_en));
    if (e_en) begin
      chk("wr_addr", int'(wr_addr), e_addr);
      chk("wr_data", int'(wr_data), e_data);
    end
    chk("frame_done", int'(frame_done), int'(e_done));
    chk("busy", int'(busy), int'(m_active));
    chk("overflow", int'(overflow), int'(m_ovf));
    if (frame_done) n_done++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
  endtask

  initial begin
    reset_n      = 0;
    start        = 0;
    image_width  = 0;
    image_height = 0;
    ready_in     = 0;
    data_in      = 0;
    n_done       = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1;

    // continuous 4x3 frame
    step(1, 4, 3, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 4, 3, 1, i);
    step(0, 4, 3, 0, 0);
    chk("t1_done_count", n_done, 1);

    // gapped stream, dims wiggled mid-frame
    n_done = 0;
    step(1, 4, 3, 0, 0);
    for (int i = 0; i < 24; i++)
      step(0, 7, 9, (i % 2) == 0, $urandom);
    step(0, 4, 3, 0, 0);
    chk("t2_done_count", n_done, 1);

    // stray pixels then start clears overflow
    for (int i = 0; i < 3; i++) step(0, 4, 3, 1, $urandom);
    chk("t3_overflow_set", int'(overflow), 1);
    step(1, 4, 3, 0, 0);
    chk("t3_overflow_clr", int'(overflow), 0);

    // restart mid-frame with coincident pixel
    n_done = 0;
    for (int i = 0; i < 5; i++) step(0, 4, 3, 1, $urandom);
    step(1, 4, 3, 1, 12'hABC);
    chk("t4_restart_addr", int'(wr_addr), 0);
    for (int i = 0; i < 11; i++) step(0, 4, 3, 1, $urandom);
    step(0, 4, 3, 0, 0);
    chk("t4_done_count", n_done, 1);

    // zero dimension ignored, then async reset mid-frame
    step(1, 0, 3, 0, 0);
    chk("t5_zero_busy", int'(busy), 0);
    step(1, 4, 3, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 4, 3, 1, $urandom);
    ready_in = 1;
    #3;
    reset_n = 0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    ready_in = 0;
    check_zero("held_reset");
    reset_n = 1;
    n_done = 0;
    step(1, 4, 3, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 4, 3, 1, $urandom);
    chk("t5_done_count", n_done, 1);

    // back-to-back 2x2 frames, start + pixel in DONE
    n_done = 0;
    step(1, 2, 2, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 2, 2, 1, $urandom);
    step(1, 2, 2, 1, 12'h5A5);
    chk("t6_b2b_addr", int'(wr_addr), 0);
    for (int i = 0; i < 3; i++) step(0, 2, 2, 1, $urandom);
    step(0, 2, 2, 0, 0);
    chk("t6_done_count", n_done, 2);
    chk("t6_no_overflow", int'(overflow), 0);

    // random traffic with small frames, including 1x1
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) == 0,
           $urandom_range(0, 4), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
